// File: rtl/act_skew_feeder.sv
// act_skew_feeder
//
// Feeds one activation vector per cycle into a systolic PE array, skewing row r
// by r cycles so that each row's activation meets its partial sum on the diagonal.
// Row r of an accepted vector appears on its active_left slice r+1 cycles after
// the accepting edge. The block also tracks the tile: it counts accepted vectors,
// stops accepting once the last vector of a tile is in, and pulses done when the
// skew pipeline has fully drained.
//
// Parameters
//   data_width  activation word width in bits
//   rows        number of PE rows fed (2..16)
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   in_valid     in_vec / in_last are valid
//   in_ready     the block accepts a vector this cycle
//   in_vec       one activation per row; row r at [(r+1)*data_width-1 : r*data_width]
//   in_last      accepted vector is the final one of the tile
//   active_left  skewed activations, same row slicing as in_vec
//   row_valid    bit r high when slice r carries real data
//   w_compute    compute enable to the PE array (OR of row_valid)
//   done         one-cycle pulse when the tile has fully drained
//   beat_count   vectors accepted in the current tile, saturating at 0xFFFF

module act_skew_feeder #(
  parameter int unsigned data_width = 20,
  parameter int unsigned rows       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [data_width*rows-1:0]   in_vec,
  input  logic                         in_last,
  output logic [data_width*rows-1:0]   active_left,
  output logic [rows-1:0]              row_valid,
  output logic                         w_compute,
  output logic                         done,
  output logic [15:0]                  beat_count
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDrain  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic        accept;
  logic [rows-1:0] row_vld_nxt;  // row_valid as it will be after the coming edge
  logic        pipe_empty_nxt;

  logic        done_q, done_d;
  logic        w_compute_q;
  logic [15:0] beat_q, beat_d;

  // Reset takes priority over any handshake in the same cycle.
  assign accept         = in_valid & in_ready & ~rst;
  assign pipe_empty_nxt = (row_vld_nxt == '0);

  // --------------------------------------------------------------------------
  // Per-row delay lines. Row r has r+1 stages; stage 0 loads the incoming
  // activation (or a zero bubble) and the last stage drives the PE row. The
  // array cannot stall, so every line shifts every cycle.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < rows; r++) begin : g_row
    logic [data_width-1:0] dat_q [r+1];
    logic [r:0]            vld_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) begin
          dat_q[k] <= '0;
        end
        vld_q <= '0;
      end else begin
        dat_q[0] <= accept ? in_vec[r*data_width +: data_width] : '0;
        vld_q[0] <= accept;
        for (int k = 1; k <= r; k++) begin
          dat_q[k] <= dat_q[k-1];
          vld_q[k] <= vld_q[k-1];
        end
      end
    end

    if (r == 0) begin : g_first
      assign row_vld_nxt[r] = accept;
    end else begin : g_later
      assign row_vld_nxt[r] = vld_q[r-1];
    end

    assign active_left[r*data_width +: data_width] = dat_q[r];
    assign row_valid[r]                            = vld_q[r];
  end

  // --------------------------------------------------------------------------
  // Tile FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Tile FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = in_last ? StDrain : StStream;
        end
      end
      StStream: begin
        if (accept && in_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pipe_empty_nxt) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Tile FSM: outputs and next values of the registered tile outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b1;
    done_d   = 1'b0;
    beat_d   = beat_q;
    unique case (state_q)
      StIdle: begin
        // First accept of a tile restarts the count at one.
        if (accept) begin
          beat_d = 16'd1;
        end
      end
      StStream: begin
        if (accept && (beat_q != 16'hFFFF)) begin
          beat_d = beat_q + 16'd1;
        end
      end
      StDrain: begin
        in_ready = 1'b0;
        // Done lands in the first cycle after the last data with every row empty.
        done_d   = pipe_empty_nxt;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q      <= 1'b0;
      w_compute_q <= 1'b0;
      beat_q      <= '0;
    end else begin
      done_q      <= done_d;
      // Registered from the same next-state bits as row_valid, so it always
      // equals |row_valid in the cycle it is seen.
      w_compute_q <= |row_vld_nxt;
      beat_q      <= beat_d;
    end
  end

  assign done       = done_q;
  assign w_compute  = w_compute_q;
  assign beat_count = beat_q;

endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 SHALL have parameter data_width, default 20, meaning the activation word width in bits.
REQ-002 SHALL have parameter rows, default 4, range 2..16, meaning the number of PE rows fed.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_vec/in_last are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a vector this cycle.
REQ-007 SHALL have port in_vec, input, data_width*rows bits: one activation per row; row r occupies bits [(r+1)*data_width-1 : r*data_width].
REQ-008 SHALL have port in_last, input, 1 bit: the accepted vector is the final one of the tile.
REQ-009 SHALL have port active_left, output, data_width*rows bits: the skewed activations, row r in the slice of REQ-007; each slice drives one PE row's active_left.
REQ-010 SHALL have port row_valid, output, rows bits: bit r is high when slice r carries real data.
REQ-011 SHALL have port w_compute, output, 1 bit: compute enable to the PE array.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when the tile has fully drained.
REQ-013 SHALL have port beat_count, output, 16 bits: number of vectors accepted in the current tile.

Function
REQ-014 SHALL define accept as in_valid & in_ready, sampled on the rising edge of clk.
REQ-015 SHALL register all outputs; no output depends combinationally on any input.
REQ-016 SHALL present row r of a vector accepted at edge t on active_left slice r, with row_valid[r]=1, during cycle t+1+r; row 0 therefore has latency 1 and row rows-1 has latency rows.
REQ-017 SHALL drive slice r to 0 with row_valid[r]=0 in any cycle in which it carries no accepted data (bubble).
REQ-018 SHALL implement a per-row data/valid delay line of depth r+1; the array has no backpressure, so the lines advance every cycle.
REQ-019 SHALL drive w_compute = OR of the registered row_valid bits; w_compute is therefore registered and equals |row_valid in the same cycle.
REQ-020 SHALL implement the FSM states IDLE, STREAM and DRAIN.
REQ-021 SHALL transition IDLE->STREAM on the first accept; if that accept has in_last=1, it SHALL transition IDLE->DRAIN directly.
REQ-022 SHALL stay in STREAM while in_valid=0; each such cycle inserts a bubble in row 0 and leaves in_ready=1.
REQ-023 SHALL transition STREAM->DRAIN on an accept with in_last=1.
REQ-024 SHALL hold in_ready=0 throughout DRAIN; in IDLE and STREAM, in_ready=1.
REQ-025 SHALL stay in DRAIN until every row_valid bit is 0, then pulse done for exactly one cycle and enter IDLE; the done cycle is the first cycle in which all row_valid bits are 0 after the last data.
REQ-026 SHALL make done occur rows+1 cycles after the last accept (last accept at edge t gives done high in cycle t+rows+1), independent of bubbles.
REQ-027 SHALL increment beat_count on every accept and hold it at the final value through DRAIN; beat_count SHALL saturate at 0xFFFF.
REQ-028 SHALL clear beat_count to 0 on the first accept of a new tile, then immediately count that accept (beat_count=1).
REQ-029 SHALL pass data through unmodified; no arithmetic or width change is applied to data.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, force the following on the next cycle: state=IDLE, all delay lines and active_left=0, row_valid=0, w_compute=0, done=0, beat_count=0, in_ready=1.
REQ-031 SHALL discard all in-flight data on a reset asserted mid-STREAM or mid-DRAIN, and SHALL NOT produce a done pulse for the aborted tile.
REQ-032 SHALL ignore in_valid in any cycle in which rst=1.

Verification
REQ-033 Single vector, in_last=1, rows=4, in_vec={4,3,2,1} -> slices 0..3 carry 1,2,3,4 in cycles t+1..t+4; w_compute high in cycles t+1..t+4; done in cycle t+5; beat_count=1.
REQ-034 Three back-to-back vectors A,B,C, C with in_last=1 -> row 2 carries A,B,C in cycles t+3..t+5; in_ready low from t+3 until done; done in cycle t+7.
REQ-035 Bubble pattern: vector at t, in_valid=0 at t+1, last vector at t+2 -> row 1 carries data at t+2, zero with row_valid=0 at t+3, data at t+4.
REQ-036 rst=1 asserted during DRAIN -> next cycle all outputs 0, in_ready=1, no done pulse; a new vector afterwards gives beat_count=1.
REQ-037 Tile of 70000 vectors -> beat_count saturates at 65535; done occurs rows+1 cycles after the last accept.
